// File: rtl/csa_pkg.sv
// csa_pkg: shared width, skip-group size and result type for the carry-skip subtractor
package csa_pkg;
    localparam int CSA_WIDTH  = 8;
    localparam int SKIP_GROUP = 2;
    typedef struct packed {
        logic [CSA_WIDTH-1:0] d;
        logic                 bout;
        logic                 ov;
        logic                 z;
    } csa_result_t;
endpackage

// File: rtl/csa_sub_half.sv
// csa_sub_half: combinational half-width carry-skip slice summing a + nb + c_i
module csa_sub_half import csa_pkg::*; #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] nb_i,
    input  logic         c_i,
    output logic [N-1:0] s_o,
    output logic         c_o
);
    localparam int G = N / SKIP_GROUP;
    logic [G:0] gc;
    logic       rc;
    logic       p;
    // ripple inside each group, skip the group carry-in past fully propagating groups
    always_comb begin
        gc    = '0;
        gc[0] = c_i;
        s_o   = '0;
        rc    = 1'b0;
        p     = 1'b0;
        for (int g = 0; g < G; g++) begin
            rc = gc[g];
            for (int k = 0; k < SKIP_GROUP; k++) begin
                p                      = a_i[g*SKIP_GROUP+k] ^ nb_i[g*SKIP_GROUP+k];
                s_o[g*SKIP_GROUP+k]    = p ^ rc;
                rc                     = (a_i[g*SKIP_GROUP+k] & nb_i[g*SKIP_GROUP+k]) | (p & rc);
            end
            gc[g+1] = rc | (&(a_i[g*SKIP_GROUP +: SKIP_GROUP] ^ nb_i[g*SKIP_GROUP +: SKIP_GROUP]) & gc[g]);
        end
    end
    assign c_o = gc[G];
endmodule

// File: rtl/csa_sub_pipe.sv
// csa_sub_pipe: two-stage valid/ready pipelined carry-skip subtractor D = A - B - Bin
module csa_sub_pipe import csa_pkg::*; #(
    parameter int WIDTH = CSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             OV,
    output logic             Z
);
    localparam int H = WIDTH / 2;
    logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
    logic [H-1:0]     d_lo_q, a_hi_q, nb_hi_q;
    logic             c_mid_q, a_msb_q, b_msb_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q, ov_q, z_q;
    logic [H-1:0]     lo_s, hi_s;
    logic             lo_c, hi_c;
    logic [WIDTH-1:0] d_full;
    logic             s2_adv, accept;

    csa_sub_half #(.N(H)) u_lo (
        .a_i(A[H-1:0]), .nb_i(~B[H-1:0]), .c_i(~Bin), .s_o(lo_s), .c_o(lo_c)
    );

    csa_sub_half #(.N(H)) u_hi (
        .a_i(a_hi_q), .nb_i(nb_hi_q), .c_i(c_mid_q), .s_o(hi_s), .c_o(hi_c)
    );

    // per-stage handshake: stage 2 drains when empty or consumed, stage 1 refills behind it
    always_comb begin
        s2_adv      = !out_valid_q || out_ready;
        in_ready    = !s1_valid_q || s2_adv;
        accept      = in_valid && in_ready;
        s1_valid_d  = accept || (s1_valid_q && !s2_adv);
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        d_full      = {hi_s, d_lo_q};
    end

    // stage 1: low half result, mid carry and upper operands captured on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            d_lo_q     <= '0;
            c_mid_q    <= 1'b0;
            a_hi_q     <= '0;
            nb_hi_q    <= '0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                d_lo_q  <= lo_s;
                c_mid_q <= lo_c;
                a_hi_q  <= A[WIDTH-1:H];
                nb_hi_q <= ~B[WIDTH-1:H];
                a_msb_q <= A[WIDTH-1];
                b_msb_q <= B[WIDTH-1];
            end
        end
    end

    // stage 2: upper half, borrow and flags; held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            ov_q        <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s2_adv && s1_valid_q) begin
                d_q    <= d_full;
                bout_q <= ~hi_c;
                ov_q   <= (a_msb_q != b_msb_q) && (d_full[WIDTH-1] != a_msb_q);
                z_q    <= d_full == '0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign Bout      = bout_q;
    assign OV        = ov_q;
    assign Z         = z_q;
endmodule
